// File: rtl/weight_fetch_if.sv
// Bus bundle between weight_fetch and its neighbours: ctrl request/finish level pair,
// weight SRAM read port, and the weight stream to the compute array.
interface weight_fetch_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              start_read_w;
  logic              read_weights_finish;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  // Stream: a word transfers on a rising edge where w_valid & w_ready; once w_valid is
  // raised, w_data/w_last hold until that transfer or an abort/reset of the load.
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic              w_last;

  modport slave (
    input  start_read_w, mem_rdata, w_ready,
    output read_weights_finish, mem_en, mem_addr, w_valid, w_data, w_last
  );

  modport master (
    output start_read_w, mem_rdata, w_ready,
    input  read_weights_finish, mem_en, mem_addr, w_valid, w_data, w_last
  );
endinterface

// File: rtl/weight_fetch.sv
// Streams NUM_WORDS weights from a 1-cycle-latency SRAM into a 2-entry FIFO feeding the
// compute array. Optional feature macro: WEIGHT_FETCH_CHECKSUM_EN adds port w_checksum.
module weight_fetch #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int NUM_WORDS = 288,
  parameter int BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           rst,
  weight_fetch_if.slave  bus,
  output logic [1:0]     dbg_state
`ifdef WEIGHT_FETCH_CHECKSUM_EN
  ,
  output logic [31:0]    w_checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   N_W      = (ADDR_W+1)'(NUM_WORDS);
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic [ADDR_W:0]   issued;
  logic [ADDR_W:0]   accepted;
  logic [1:0]        count;
  logic [1:0]        count_nx;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              rd_pend;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              push;
  logic              pop;
  logic              issue;

  assign dbg_state   = state;
  assign bus.w_valid = (state == S_FETCH) && (count != 2'd0);
  assign bus.w_data  = fifo_mem[rd_ptr];
  assign bus.w_last  = bus.w_valid && (accepted == LAST_IDX);

  // rd_pend marks the cycle mem_rdata carries the word requested one cycle earlier.
  assign push = rd_pend;
  assign pop  = bus.w_valid && bus.w_ready;

  always_comb begin
    count_nx = count + {1'b0, push} - {1'b0, pop};
  end

  // Outstanding reservation (FIFO after this edge plus the read now on the SRAM port)
  // must leave room for one more word, so the FIFO can never overflow.
  assign issue = (issued < N_W) &&
                 (({1'b0, count_nx} + {2'b00, bus.mem_en}) < 3'd2);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                   <= S_IDLE;
      bus.read_weights_finish <= 1'b0;
      bus.mem_en              <= 1'b0;
      bus.mem_addr            <= BASE;
      issued                  <= '0;
      accepted                <= '0;
      count                   <= '0;
      wr_ptr                  <= 1'b0;
      rd_ptr                  <= 1'b0;
      rd_pend                 <= 1'b0;
`ifdef WEIGHT_FETCH_CHECKSUM_EN
      w_checksum              <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          rd_pend  <= 1'b0;
          count    <= '0;
          wr_ptr   <= 1'b0;
          rd_ptr   <= 1'b0;
          accepted <= '0;
          if (bus.start_read_w) begin
            state        <= S_FETCH;
            bus.mem_en   <= 1'b1;
            bus.mem_addr <= BASE;
            issued       <= (ADDR_W+1)'(1);
`ifdef WEIGHT_FETCH_CHECKSUM_EN
            w_checksum   <= '0;
`endif
          end else begin
            bus.mem_en <= 1'b0;
            issued     <= '0;
          end
        end

        S_FETCH: begin
          if (!bus.start_read_w) begin
            // Abort: flush the FIFO and forget any read still returning.
            state      <= S_IDLE;
            bus.mem_en <= 1'b0;
            rd_pend    <= 1'b0;
            count      <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
          end else begin
            rd_pend <= bus.mem_en;
            count   <= count_nx;
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
              rd_ptr   <= ~rd_ptr;
              accepted <= accepted + 1'b1;
`ifdef WEIGHT_FETCH_CHECKSUM_EN
              w_checksum <= w_checksum + 32'(bus.w_data);
`endif
              if (accepted == LAST_IDX) begin
                state                   <= S_DONE;
                bus.read_weights_finish <= 1'b1;
              end
            end
            bus.mem_en <= issue;
            if (issue) begin
              bus.mem_addr <= BASE + issued[ADDR_W-1:0];
              issued       <= issued + 1'b1;
            end
          end
        end

        S_DONE: begin
          bus.mem_en <= 1'b0;
          if (!bus.start_read_w) begin
            state                   <= S_IDLE;
            bus.read_weights_finish <= 1'b0;
          end
        end

        default: begin
          state                   <= S_IDLE;
          bus.mem_en              <= 1'b0;
          bus.read_weights_finish <= 1'b0;
        end
      endcase
    end
  end

endmodule
